// File: rtl/serial_cplx_pkg.sv
// Shared definitions for the bit-serial complement sequencer: FSM encoding
// and a constant-width helper.
package serial_cplx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Ceiling log2; elaboration-time only.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bit_delay_line.sv
// Single-bit delay of DEPTH clock cycles; DEPTH=0 degenerates to a wire.
module bit_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic t_clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q_o = d_i;
        end else begin : g_sr
            logic [DEPTH-1:0] sr_q;

            always_ff @(posedge t_clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr_q <= '0;
                end else begin
                    sr_q <= DEPTH'({sr_q, d_i});
                end
            end

            assign q_o = sr_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/serial_negate_ctrl.sv
// Sequencer around an external bit-serial negator: accepts a parallel word,
// streams it LSB-first with a bit-0 strobe, and reassembles the returned bits.
module serial_negate_ctrl
    import serial_cplx_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int DP_LAT = 1
) (
    input  logic             t_clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_i,
    output logic             ser_r,
    input  logic             ser_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int               CNT_W    = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q;
    logic [WIDTH-1:0] tx_sr_q;
    logic [WIDTH-1:0] rx_sr_q;
    logic [WIDTH-1:0] rx_sr_d;
    logic [WIDTH-1:0] out_data_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [CNT_W-1:0] rx_cnt_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             ser_i_q;
    logic             ser_r_q;
    logic             busy_q;
    logic             issue;
    logic             capture;
    logic             rx_full;

    // A bit is on ser_i for exactly the cycles spent in SHIFT; delaying that
    // flag by the datapath latency marks the cycles whose ser_y is valid.
    assign issue = (state_q == ST_SHIFT);

    bit_delay_line #(
        .DEPTH(DP_LAT)
    ) u_issue_dly (
        .t_clk(t_clk),
        .rst_n(rst_n),
        .d_i  (issue),
        .q_o  (capture)
    );

    always_comb begin
        rx_sr_d  = rx_sr_q;
        rx_cnt_d = rx_cnt_q;
        if (capture) begin
            rx_sr_d  = {ser_y, rx_sr_q[WIDTH-1:1]};
            rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
    end

    assign rx_full = capture && (rx_cnt_d == FULL_CNT);

    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            out_data_q  <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ser_i_q     <= 1'b0;
            ser_r_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_sr_q  <= rx_sr_d;
            rx_cnt_q <= rx_cnt_d;

            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        tx_sr_q    <= in_data;
                        tx_cnt_q   <= '0;
                        rx_cnt_q   <= '0;
                        ser_i_q    <= in_data[0];
                        ser_r_q    <= 1'b1;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    tx_sr_q  <= tx_sr_q >> 1;
                    tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    ser_r_q  <= 1'b0;
                    if (tx_cnt_q == LAST_BIT) begin
                        ser_i_q <= 1'b0;
                        state_q <= rx_full ? ST_DONE : ST_DRAIN;
                    end else begin
                        ser_i_q <= tx_sr_q[1];
                    end
                end
                ST_DRAIN: begin
                    if (rx_full) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // The final capture can land in SHIFT (DP_LAT=0) or in DRAIN.
            if (rx_full) begin
                out_valid_q <= 1'b1;
                out_data_q  <= rx_sr_d;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ser_i     = ser_i_q;
    assign ser_r     = ser_r_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Bench for serial_negate_ctrl: three builds (DP_LAT 1, 3, 0), each wrapped
// around a behavioural bit-serial negator.
module tb_serial_negate_ctrl;

    localparam int W = 12;
    localparam int N_RAND = 500;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] dout;
    } vec_t;

    logic         t_clk;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [W-1:0] in_data   [3];
    logic         ser_i     [3];
    logic         ser_r     [3];
    logic         ser_y     [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [W-1:0] out_data  [3];
    logic         busy      [3];

    int checks = 0;
    int errors = 0;
    int rcnt0  = 0;

    initial begin
        t_clk = 1'b0;
        forever #5 t_clk = ~t_clk;
    end

    function automatic int lat_of(input int idx);
        return (idx == 0) ? 1 : (idx == 1) ? 3 : 0;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_build
        localparam int L = (gi == 0) ? 1 : (gi == 1) ? 3 : 0;
        logic seen_q;
        logic seen_eff;
        logic y_comb;

        // Serial two's complement: copy bits up to and including the first 1,
        // invert every bit after it; the bit-0 strobe forgets the previous word.
        assign seen_eff = ser_r[gi] ? 1'b0 : seen_q;
        assign y_comb   = ser_i[gi] ^ seen_eff;

        always @(posedge t_clk) seen_q <= seen_eff | ser_i[gi];

        if (L == 0) begin : g_comb
            assign ser_y[gi] = y_comb;
        end else begin : g_pipe
            logic [L-1:0] pipe;
            always @(posedge t_clk) begin
                pipe[0] <= y_comb;
                for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
            end
            assign ser_y[gi] = pipe[L-1];
        end

        serial_negate_ctrl #(
            .WIDTH (W),
            .DP_LAT(L)
        ) dut (
            .t_clk    (t_clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[gi]),
            .in_ready (in_ready[gi]),
            .in_data  (in_data[gi]),
            .ser_i    (ser_i[gi]),
            .ser_r    (ser_r[gi]),
            .ser_y    (ser_y[gi]),
            .out_valid(out_valid[gi]),
            .out_ready(out_ready[gi]),
            .out_data (out_data[gi]),
            .busy     (busy[gi])
        );
    end

    always @(negedge t_clk) if (ser_r[0]) rcnt0 <= rcnt0 + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input int idx, input string tag);
        chk({tag, "_in_ready"},  in_ready[idx],  1);
        chk({tag, "_out_valid"}, out_valid[idx], 0);
        chk({tag, "_out_data"},  out_data[idx],  0);
        chk({tag, "_ser_i"},     ser_i[idx],     0);
        chk({tag, "_ser_r"},     ser_r[idx],     0);
        chk({tag, "_busy"},      busy[idx],      0);
    endtask

    task automatic wait_out_valid(input int idx, input string nm);
        int n;
        n = 0;
        while (!out_valid[idx] && n < 100) begin
            @(negedge t_clk);
            n++;
        end
        chk({nm, "_valid_seen"}, out_valid[idx], 1);
    endtask

    task automatic take_result(input int idx);
        @(negedge t_clk);
        out_ready[idx] = 1'b1;
        @(posedge t_clk);
        #1 out_ready[idx] = 1'b0;
    endtask

    // Offers one word, checks the bit-0 strobe, returns result and edge latency.
    task automatic send_word(input int idx, input logic [W-1:0] d,
                             output logic [W-1:0] res, output int lat);
        int n;
        int r0;
        res = '0;
        lat = -1;
        @(negedge t_clk);
        in_valid[idx] = 1'b1;
        in_data[idx]  = d;
        n = 0;
        while (!in_ready[idx] && n < 100) begin
            @(negedge t_clk);
            n++;
        end
        if (!in_ready[idx]) begin
            chk("accept_timeout", in_ready[idx], 1);
            in_valid[idx] = 1'b0;
            return;
        end
        r0 = rcnt0;
        @(posedge t_clk);
        #1 in_valid[idx] = 1'b0;
        @(negedge t_clk);
        chk("ser_r_bit0", ser_r[idx], 1);
        chk("ser_i_bit0", ser_i[idx], d[0]);
        n = 0;
        while (n < 100) begin
            @(posedge t_clk);
            n++;
            #1;
            if (out_valid[idx]) break;
        end
        if (!out_valid[idx]) begin
            chk("result_timeout", out_valid[idx], 1);
            return;
        end
        lat = n;
        if (idx == 0) chk("ser_r_once", rcnt0 - r0, 1);
        res = out_data[idx];
        take_result(idx);
    endtask

    initial begin
        #700000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[9];
        logic [W-1:0] res;
        logic [W-1:0] exp_q[$];
        logic [W-1:0] last_data;
        logic         hold;
        int           lat;
        int           n;
        int           sent;
        int           got;
        int           gap;
        bit           acc;

        vecs[0] = '{12'h00D, 12'hFF3};
        vecs[1] = '{12'h000, 12'h000};
        vecs[2] = '{12'h800, 12'h800};
        vecs[3] = '{12'hFFF, 12'h001};
        vecs[4] = '{12'h123, 12'hEDD};
        vecs[5] = '{12'h456, 12'hBAA};
        vecs[6] = '{12'h0A5, 12'hF5B};
        vecs[7] = '{12'h001, 12'hFFF};
        vecs[8] = '{12'h7FF, 12'h801};

        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            out_ready[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge t_clk);
        for (int i = 0; i < 3; i++) chk_reset(i, "por");
        rst_n = 1'b1;

        // Directed vectors on the DP_LAT=1 build.
        foreach (vecs[i]) begin
            send_word(0, vecs[i].din, res, lat);
            $display("vec %0d in=%03h out=%03h lat=%0d", i, vecs[i].din, res, lat);
            chk("vec_data", res, vecs[i].dout);
            chk("vec_latency", lat, W + lat_of(0));
        end

        // Back-to-back with in_valid held and a stalled consumer.
        @(negedge t_clk);
        in_valid[0] = 1'b1;
        in_data[0]  = 12'h123;
        n = 0;
        while (!in_ready[0] && n < 100) begin
            @(negedge t_clk);
            n++;
        end
        @(posedge t_clk);
        #1 in_data[0] = 12'h456;
        wait_out_valid(0, "b2b_first");
        for (int k = 0; k < 5; k++) begin
            chk("b2b_hold_valid", out_valid[0], 1);
            chk("b2b_hold_data", out_data[0], 12'hEDD);
            chk("b2b_hold_in_ready", in_ready[0], 0);
            @(negedge t_clk);
        end
        $display("b2b first out=%03h", out_data[0]);
        out_ready[0] = 1'b1;
        @(posedge t_clk);
        #1 out_ready[0] = 1'b0;
        @(negedge t_clk);
        chk("b2b_ready_again", in_ready[0], 1);
        @(posedge t_clk);
        #1 in_valid[0] = 1'b0;
        wait_out_valid(0, "b2b_second");
        chk("b2b_second_data", out_data[0], 12'hBAA);
        $display("b2b second out=%03h", out_data[0]);
        take_result(0);

        // Asynchronous reset while bit 5 of 0x0A5 is on the wire.
        @(negedge t_clk);
        in_valid[0] = 1'b1;
        in_data[0]  = 12'h0A5;
        n = 0;
        while (!in_ready[0] && n < 100) begin
            @(negedge t_clk);
            n++;
        end
        @(posedge t_clk);
        #1 in_valid[0] = 1'b0;
        repeat (5) @(posedge t_clk);
        #1 chk("midword_ser_i_bit5", ser_i[0], 1);
        chk("midword_busy", busy[0], 1);
        #1 rst_n = 1'b0;
        #1 chk_reset(0, "async_rst");
        @(negedge t_clk);
        @(negedge t_clk);
        rst_n = 1'b1;
        send_word(0, 12'h0A5, res, lat);
        $display("post-reset in=0a5 out=%03h lat=%0d", res, lat);
        chk("post_reset_data", res, 12'hF5B);

        // Other datapath latencies.
        for (int idx = 1; idx < 3; idx++) begin
            send_word(idx, 12'h00D, res, lat);
            $display("dp_lat=%0d in=00d out=%03h lat=%0d", lat_of(idx), res, lat);
            chk("lat_build_data", res, 12'hFF3);
            chk("lat_build_latency", lat, W + lat_of(idx));
        end

        // Random traffic against a queue of arithmetically negated words.
        sent = 0;
        got  = 0;
        gap  = 0;
        acc  = 1'b0;
        hold = 1'b0;
        last_data = '0;
        for (int cyc = 0; cyc < 20000 && got < N_RAND; cyc++) begin
            @(negedge t_clk);
            if (hold) begin
                chk("rand_stall_valid", out_valid[0], 1);
                chk("rand_stall_data", out_data[0], last_data);
            end
            out_ready[0] = ($urandom_range(0, 3) != 0);
            hold = out_valid[0] && !out_ready[0];
            last_data = out_data[0];
            if (out_valid[0] && out_ready[0]) begin
                if (exp_q.size() == 0) begin
                    chk("rand_spurious", 1, 0);
                end else begin
                    res = exp_q.pop_front();
                    $display("rand %0d out=%03h exp=%03h", got, out_data[0], res);
                    chk("rand_word", out_data[0], res);
                end
                got++;
            end
            if (acc) begin
                acc = 1'b0;
                in_valid[0] = 1'b0;
                gap = $urandom_range(0, 3);
            end
            if (!in_valid[0] && sent < N_RAND) begin
                if (gap == 0) begin
                    in_valid[0] = 1'b1;
                    in_data[0]  = W'($urandom);
                end else begin
                    gap--;
                end
            end
            if (in_valid[0] && in_ready[0]) begin
                exp_q.push_back(W'((4096 - int'(in_data[0])) % 4096));
                acc = 1'b1;
                sent++;
            end
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        chk("rand_count", got, N_RAND);
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
